// File: rtl/dmem_block_responder.sv
// ============================================================================
//  Module   : dmem_block_responder
//  Purpose  : Block-organised data memory answering cache fills and
//             write-backs with a fixed multi-cycle latency and a
//             combinational busywait handshake.
//             Optional access counters: define DMEM_ACCESS_COUNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_block_responder #(
    parameter int LATENCY    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  busywait
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [15:0]           read_count,
    output logic [15:0]           write_count
`endif
);

    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [7:0]              counter;
    logic                    op_write;
    logic [ADDR_WIDTH-1:0]   addr_lat;
    logic [DATA_WIDTH-1:0]   wdata_lat;
    logic                    request;
    logic                    complete;

    // Contents survive reset; only power-up starts them at zero.
    logic [DATA_WIDTH-1:0]   mem [DEPTH] = '{default: '0};

    assign request  = read | write;
    assign complete = (state == BUSY) && (counter == 8'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busywait   = 1'b0;
        case (state)
            IDLE: begin
                busywait = request;
                if (request) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                busywait = 1'b1;
                if (counter == 8'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                // Requests still high here are ignored so the cache sees completion.
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (reset) begin
            busywait = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter  <= 8'd0;
            readdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        op_write  <= write;
                        addr_lat  <= address;
                        wdata_lat <= writedata;
                        counter   <= LAT_M1;
                    end
                end
                BUSY: begin
                    if (counter != 8'd0) begin
                        counter <= counter - 8'd1;
                    end else if (!op_write) begin
                        readdata <= mem[addr_lat];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && complete && op_write) begin
            mem[addr_lat] <= wdata_lat;
        end
    end

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            read_count  <= 16'd0;
            write_count <= 16'd0;
        end else if (complete) begin
            if (op_write) begin
                if (write_count != 16'hFFFF) begin
                    write_count <= write_count + 16'd1;
                end
            end else begin
                if (read_count != 16'hFFFF) begin
                    read_count <= read_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

`default_nettype wire
